// File: rtl/ahb_pkg.sv
// Shared AHB encodings for the manager and the dummy subordinate.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ahb_pkg;

   // Transfer type; this manager only ever drives IDLE and NONSEQ
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } trans_t;

   // Subordinate response; anything other than OKAY is handled as an error
   typedef enum logic [1:0] {
      OKAY  = 2'd0,
      ERROR = 2'd1,
      RETRY = 2'd2,
      SPLIT = 2'd3
   } resp_t;

   localparam int CtrlWidth = 4;

endpackage

// File: rtl/ahb_manager_dummy_if.sv
// Command, AHB bus and completion signals of the simple AHB manager.
// Latency: n/a (wiring only).
// Backpressure: reqReady on the command side, readyOut on the AHB side.
interface ahb_manager_dummy_if
   import ahb_pkg::*;
#(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   // command port
   logic                 reqValid;
   logic                 reqReady;
   logic [AddrWidth-1:0] reqAddr;
   logic [DataWidth-1:0] reqWData;
   logic                 reqWrite;
   logic [CtrlWidth-1:0] reqControl;
   // AHB manager side
   logic [AddrWidth-1:0] addr;
   logic [DataWidth-1:0] wData;
   logic [CtrlWidth-1:0] control;
   logic [1:0]           trans;
   logic                 write;
   logic [DataWidth-1:0] rData;
   logic [1:0]           resp;
   logic                 readyOut;
   // completion port
   logic                 rspValid;
   logic [DataWidth-1:0] rspRData;
   logic                 rspError;

   // the manager block itself
   modport master (
      input  reqValid, reqAddr, reqWData, reqWrite, reqControl,
      input  rData, resp, readyOut,
      output reqReady, addr, wData, control, trans, write,
      output rspValid, rspRData, rspError
   );

   // the environment: command source, subordinate and completion sink
   modport slave (
      output reqValid, reqAddr, reqWData, reqWrite, reqControl,
      output rData, resp, readyOut,
      input  reqReady, addr, wData, control, trans, write,
      input  rspValid, rspRData, rspError
   );

endinterface

// File: rtl/ahb_manager_dummy.sv
// Simple AHB manager: single read/write commands issued as overlapped NONSEQ transfers.
// Latency: accept at edge N -> NONSEQ in N+1 -> data phase N+2 -> rspValid in N+3.
// Backpressure: reqReady drops while the address slot cannot move (wait state or ERROR).
module ahb_manager_dummy
   import ahb_pkg::*;
#(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
) (
   input  logic                clk,
   input  logic                reset,
   ahb_manager_dummy_if.master bus
);

   // address slot
   logic                 a_vld_q,   a_vld_d;
   logic [AddrWidth-1:0] a_addr_q,  a_addr_d;
   logic                 a_write_q, a_write_d;
   logic [CtrlWidth-1:0] a_ctrl_q,  a_ctrl_d;
   logic [DataWidth-1:0] a_wdata_q, a_wdata_d;
   // data slot
   logic                 d_vld_q,   d_vld_d;
   logic                 d_write_q, d_write_d;
   logic [DataWidth-1:0] wdata_q,   wdata_d;
   // error hold and completion
   logic                 err_hold_q,  err_hold_d;
   logic                 rsp_vld_q,   rsp_vld_d;
   logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_err_q,   rsp_err_d;

   logic resp_bad;
   logic err_first;
   logic req_ready;
   logic accept;
   logic advance;
   logic d_done;

   // first cycle of a two-cycle error response: readyOut low with a non-OKAY resp
   assign resp_bad  = (bus.resp != OKAY);
   assign err_first = d_vld_q && !bus.readyOut && resp_bad;
   assign req_ready = !reset && !err_hold_q && (!a_vld_q || (bus.readyOut && !err_first));
   assign accept    = bus.reqValid && req_ready;
   // slots only move on a ready edge outside the error hold cycle
   assign advance   = bus.readyOut && !err_hold_q;
   assign d_done    = d_vld_q && bus.readyOut;

   // next-state for slots, error hold and completion
   always_comb begin
      a_vld_d     = a_vld_q;
      a_addr_d    = a_addr_q;
      a_write_d   = a_write_q;
      a_ctrl_d    = a_ctrl_q;
      a_wdata_d   = a_wdata_q;
      d_vld_d     = d_vld_q;
      d_write_d   = d_write_q;
      wdata_d     = wdata_q;
      err_hold_d  = err_hold_q;
      rsp_vld_d   = d_done;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      if (accept) begin
         a_vld_d   = 1'b1;
         a_addr_d  = bus.reqAddr;
         a_write_d = bus.reqWrite;
         a_ctrl_d  = bus.reqControl;
         a_wdata_d = bus.reqWData;
      end else if (advance) begin
         a_vld_d = 1'b0;
      end

      if (advance) begin
         d_vld_d   = a_vld_q;
         d_write_d = a_write_q;
         wdata_d   = a_wdata_q;
      end else if (d_done) begin
         // errored transfer finishing while the address slot stays parked
         d_vld_d = 1'b0;
      end

      if (err_first) begin
         err_hold_d = 1'b1;
      end else if (err_hold_q && bus.readyOut) begin
         err_hold_d = 1'b0;
      end

      if (d_done) begin
         rsp_err_d   = resp_bad || err_hold_q;
         rsp_rdata_d = d_write_q ? '0 : bus.rData;
      end
   end

   // state registers with synchronous reset; reset abandons any transfer in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         a_vld_q     <= 1'b0;
         a_addr_q    <= '0;
         a_write_q   <= 1'b0;
         a_ctrl_q    <= '0;
         a_wdata_q   <= '0;
         d_vld_q     <= 1'b0;
         d_write_q   <= 1'b0;
         wdata_q     <= '0;
         err_hold_q  <= 1'b0;
         rsp_vld_q   <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         a_vld_q     <= a_vld_d;
         a_addr_q    <= a_addr_d;
         a_write_q   <= a_write_d;
         a_ctrl_q    <= a_ctrl_d;
         a_wdata_q   <= a_wdata_d;
         d_vld_q     <= d_vld_d;
         d_write_q   <= d_write_d;
         wdata_q     <= wdata_d;
         err_hold_q  <= err_hold_d;
         rsp_vld_q   <= rsp_vld_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.reqReady = req_ready;
   assign bus.trans    = (a_vld_q && !err_hold_q) ? NONSEQ : IDLE;
   assign bus.addr     = a_addr_q;
   assign bus.write    = a_write_q;
   assign bus.control  = a_ctrl_q;
   assign bus.wData    = wdata_q;
   assign bus.rspValid = rsp_vld_q;
   assign bus.rspRData = rsp_rdata_q;
   assign bus.rspError = rsp_err_q;

endmodule

// File: tb/tb_ahb_manager_dummy.sv
// Bench for the simple AHB manager: directed cycle checks plus a response scoreboard.
// Latency: checks the N+1 / N+2 / N+3 address, data and completion timing.
// Backpressure: exercises wait states, the two-cycle ERROR and reset mid-transfer.
module tb_ahb_manager_dummy;
   import ahb_pkg::*;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;
   int   n_rsp   = 0;
   int   n_exp   = 0;
   exp_t sb[$];
   exp_t e;

   ahb_manager_dummy_if bus();

   ahb_manager_dummy dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic v, input logic [31:0] a, input logic [31:0] wd,
                      input logic w, input logic [3:0] ctrl);
      bus.reqValid   = v;
      bus.reqAddr    = a;
      bus.reqWData   = wd;
      bus.reqWrite   = w;
      bus.reqControl = ctrl;
   endtask

   task automatic expect_rsp(input logic err, input logic [31:0] rdata);
      sb.push_back({err, rdata});
      n_exp++;
   endtask

   task automatic sub(input logic rdy, input logic [1:0] rsp, input logic [31:0] rd);
      bus.readyOut = rdy;
      bus.resp     = rsp;
      bus.rData    = rd;
   endtask

   // completion monitor: every rspValid pops one scoreboard entry
   initial begin
      forever begin
         @(negedge clk);
         if (bus.rspValid === 1'b1) begin
            n_rsp++;
            if (sb.size() == 0) begin
               chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_rdata", bus.rspRData, e.rdata);
               chk("rsp_err",   bus.rspError, e.err);
            end
         end
      end
   end

   initial begin
      req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      sub(1'b1, 2'd0, 32'h0);

      // reset state
      nxt();
      nxt();
      #1;
      chk("rst_trans",    bus.trans,    2'd0);
      chk("rst_addr",     bus.addr,     32'h0);
      chk("rst_wdata",    bus.wData,    32'h0);
      chk("rst_write",    bus.write,    1'b0);
      chk("rst_control",  bus.control,  4'h0);
      chk("rst_rspvalid", bus.rspValid, 1'b0);
      chk("rst_rsprdata", bus.rspRData, 32'h0);
      chk("rst_rsperror", bus.rspError, 1'b0);
      chk("rst_reqready", bus.reqReady, 1'b0);

      // single zero-wait write
      reset = 1'b0;
      req(1'b1, 32'h1000, 32'hDEADBEEF, 1'b1, 4'h3);
      expect_rsp(1'b0, 32'h0);
      #1;
      chk("wr_reqready", bus.reqReady, 1'b1);
      nxt();
      req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      #1;
      chk("wr_trans_c1", bus.trans,   2'd2);
      chk("wr_addr_c1",  bus.addr,    32'h1000);
      chk("wr_write_c1", bus.write,   1'b1);
      chk("wr_ctrl_c1",  bus.control, 4'h3);
      nxt();
      #1;
      chk("wr_wdata_c2", bus.wData, 32'hDEADBEEF);
      chk("wr_trans_c2", bus.trans, 2'd0);
      nxt();
      #1;
      chk("wr_rspvalid_c3", bus.rspValid, 1'b1);
      chk("wr_rsperror_c3", bus.rspError, 1'b0);

      // three back-to-back reads
      nxt();
      req(1'b1, 32'h0, 32'h0, 1'b0, 4'h2);
      expect_rsp(1'b0, 32'h11);
      expect_rsp(1'b0, 32'h22);
      expect_rsp(1'b0, 32'h33);
      nxt();
      req(1'b1, 32'h4, 32'h0, 1'b0, 4'h2);
      #1;
      chk("b2b_trans_c1",  bus.trans,    2'd2);
      chk("b2b_addr_c1",   bus.addr,     32'h0);
      chk("b2b_ready_c1",  bus.reqReady, 1'b1);
      nxt();
      req(1'b1, 32'h8, 32'h0, 1'b0, 4'h2);
      sub(1'b1, 2'd0, 32'h11);
      #1;
      chk("b2b_trans_c2",  bus.trans, 2'd2);
      chk("b2b_addr_c2",   bus.addr,  32'h4);
      nxt();
      req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      sub(1'b1, 2'd0, 32'h22);
      #1;
      chk("b2b_trans_c3",  bus.trans,    2'd2);
      chk("b2b_addr_c3",   bus.addr,     32'h8);
      chk("b2b_rsp_c3",    bus.rspValid, 1'b1);
      chk("b2b_rdata_c3",  bus.rspRData, 32'h11);
      nxt();
      sub(1'b1, 2'd0, 32'h33);
      #1;
      chk("b2b_trans_c4",  bus.trans,    2'd0);
      chk("b2b_rdata_c4",  bus.rspRData, 32'h22);
      nxt();
      #1;
      chk("b2b_rsp_c5",    bus.rspValid, 1'b1);
      chk("b2b_rdata_c5",  bus.rspRData, 32'h33);

      // read with two wait states, a second read queued behind it
      nxt();
      sub(1'b1, 2'd0, 32'h0);
      req(1'b1, 32'h3000, 32'h0, 1'b0, 4'h1);
      expect_rsp(1'b0, 32'h55);
      expect_rsp(1'b0, 32'h66);
      nxt();
      req(1'b1, 32'h3004, 32'h0, 1'b0, 4'h1);
      #1;
      chk("ws_trans_c1", bus.trans, 2'd2);
      chk("ws_ready_c1", bus.reqReady, 1'b1);
      for (int i = 0; i < 2; i++) begin
         nxt();
         req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
         sub(1'b0, 2'd0, 32'h0);
         #1;
         chk("ws_trans_wait", bus.trans,    2'd2);
         chk("ws_addr_wait",  bus.addr,     32'h3004);
         chk("ws_ready_wait", bus.reqReady, 1'b0);
         chk("ws_rsp_wait",   bus.rspValid, 1'b0);
      end
      nxt();
      sub(1'b1, 2'd0, 32'h55);
      #1;
      chk("ws_trans_c4", bus.trans,    2'd2);
      chk("ws_addr_c4",  bus.addr,     32'h3004);
      chk("ws_ready_c4", bus.reqReady, 1'b1);
      nxt();
      sub(1'b1, 2'd0, 32'h66);
      #1;
      chk("ws_rsp_c5",   bus.rspValid, 1'b1);
      chk("ws_rdata_c5", bus.rspRData, 32'h55);
      chk("ws_trans_c5", bus.trans,    2'd0);
      nxt();
      #1;
      chk("ws_rsp_c6",   bus.rspValid, 1'b1);
      chk("ws_rdata_c6", bus.rspRData, 32'h66);

      // write 0x2000 errors while read 0x2004 waits in the address slot
      nxt();
      sub(1'b1, 2'd0, 32'h0);
      req(1'b1, 32'h2000, 32'hA5A5A5A5, 1'b1, 4'h3);
      expect_rsp(1'b1, 32'h0);
      expect_rsp(1'b0, 32'h77);
      nxt();
      req(1'b1, 32'h2004, 32'h0, 1'b0, 4'h3);
      nxt();
      req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      sub(1'b0, 2'd1, 32'h0);
      #1;
      chk("err_trans_e1", bus.trans,    2'd2);
      chk("err_addr_e1",  bus.addr,     32'h2004);
      chk("err_ready_e1", bus.reqReady, 1'b0);
      nxt();
      sub(1'b1, 2'd1, 32'h0);
      #1;
      chk("err_trans_e2", bus.trans,    2'd0);
      chk("err_ready_e2", bus.reqReady, 1'b0);
      nxt();
      sub(1'b1, 2'd0, 32'h0);
      #1;
      chk("err_rsp_e3",   bus.rspValid, 1'b1);
      chk("err_rsperr_e3", bus.rspError, 1'b1);
      chk("err_trans_e3", bus.trans,    2'd2);
      chk("err_addr_e3",  bus.addr,     32'h2004);
      nxt();
      sub(1'b1, 2'd0, 32'h77);
      #1;
      chk("err_trans_e4", bus.trans, 2'd0);
      nxt();
      #1;
      chk("err_rsp_e5",    bus.rspValid, 1'b1);
      chk("err_rsperr_e5", bus.rspError, 1'b0);

      // reset during the data phase of a read: no response may appear
      nxt();
      sub(1'b1, 2'd0, 32'h0);
      req(1'b1, 32'h4000, 32'h0, 1'b0, 4'h0);
      nxt();
      req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      nxt();
      reset = 1'b1;
      sub(1'b1, 2'd0, 32'h99);
      #1;
      chk("rstmid_ready", bus.reqReady, 1'b0);
      nxt();
      #1;
      chk("rstmid_trans", bus.trans,    2'd0);
      chk("rstmid_rsp",   bus.rspValid, 1'b0);
      chk("rstmid_ready2", bus.reqReady, 1'b0);
      nxt();
      reset = 1'b0;
      req(1'b1, 32'h5000, 32'h1234, 1'b1, 4'h5);
      expect_rsp(1'b0, 32'h0);
      #1;
      chk("post_ready", bus.reqReady, 1'b1);
      nxt();
      req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      #1;
      chk("post_trans", bus.trans,   2'd2);
      chk("post_addr",  bus.addr,    32'h5000);
      chk("post_ctrl",  bus.control, 4'h5);
      nxt();
      #1;
      chk("post_wdata", bus.wData, 32'h1234);
      nxt();
      #1;
      chk("post_rsp", bus.rspValid, 1'b1);

      // idle: no command for 10 cycles
      for (int i = 0; i < 10; i++) begin
         nxt();
         #1;
         chk("idle_trans", bus.trans,    2'd0);
         chk("idle_rsp",   bus.rspValid, 1'b0);
      end

      chk("sb_left",   sb.size(), 0);
      chk("rsp_count", n_rsp,     n_exp);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
